// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB bus arbiter with burst and lock hold
//
// Shares the AHB address/data bus (and the ahb2apb bridge behind it) among
// NUM_MASTERS masters. The bus parks on DEFAULT_MASTER when nobody requests.
// Ownership is held for the full length of fixed-length bursts and while the
// address-phase owner keeps HLOCK and HBUSREQ asserted.
//
// Ports:
//   HCLK       in   AHB clock
//   HRST_N     in   asynchronous active-low reset
//   HBUSREQ    in   per-master bus request
//   HLOCK      in   per-master locked-transfer request
//   HTRANS     in   address-phase transfer type of the current owner
//   HBURST     in   address-phase burst type of the current owner
//   HREADY     in   bus-wide ready; all state advances only when high
//   HGRANT     out  one-hot grant, registered
//   HMASTER    out  index of the address-phase owner, registered
//   HMASTLOCK  out  current address phase belongs to a locked sequence

module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRST_N,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic {ST_ARB, ST_BURST} state_t;

  state_t           state, state_nxt;
  logic [3:0]       beat_cnt, beat_cnt_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] grant_idx, grant_idx_nxt;
  logic [IDX_W-1:0] owner_idx;

  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic             lock_hold;
  logic [IDX_W-1:0] arb_idx, arb_ptr;
  logic             fixed_burst;
  logic [3:0]       burst_len_m1;
  logic             do_arb;

  assign owner_idx = HMASTER[IDX_W-1:0];

  // Encode the registered one-hot grant.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANT[i]) grant_idx = IDX_W'(i);
    end
  end

  // First requester strictly after the pointer, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_ptr;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!rr_found && HBUSREQ[IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS)]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
      end
    end
  end

  // Grant selection used whenever the arbiter is free to move the bus.
  // The lock test looks at the address-phase owner, not the pending grant.
  always_comb begin
    lock_hold = HLOCK[owner_idx] & HBUSREQ[owner_idx];
    arb_idx   = DEF_IDX;
    arb_ptr   = rr_ptr;
    if (lock_hold) begin
      arb_idx = grant_idx;
    end else if (rr_found) begin
      arb_idx = rr_idx;
      arb_ptr = rr_idx;
    end
  end

  // WRAP4/INCR4 -> 3, WRAP8/INCR8 -> 7, WRAP16/INCR16 -> 15 remaining SEQ beats.
  always_comb begin
    fixed_burst  = HBURST[2] | HBURST[1];
    burst_len_m1 = 4'd0;
    case (HBURST[2:1])
      2'b01:   burst_len_m1 = 4'd3;
      2'b10:   burst_len_m1 = 4'd7;
      2'b11:   burst_len_m1 = 4'd15;
      default: burst_len_m1 = 4'd0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    rr_ptr_nxt    = rr_ptr;
    grant_idx_nxt = grant_idx;
    do_arb        = 1'b0;

    case (state)
      ST_ARB: begin
        if (HTRANS == TR_NONSEQ && fixed_burst) begin
          state_nxt    = ST_BURST;
          beat_cnt_nxt = burst_len_m1;
        end else begin
          do_arb = 1'b1;
        end
      end
      ST_BURST: begin
        case (HTRANS)
          TR_SEQ: begin
            // Last address beat: hand over so the next owner is granted
            // during the final data phase.
            if (beat_cnt == 4'd1) begin
              state_nxt    = ST_ARB;
              beat_cnt_nxt = 4'd0;
              do_arb       = 1'b1;
            end else begin
              beat_cnt_nxt = beat_cnt - 4'd1;
            end
          end
          TR_BUSY: begin
          end
          default: begin
            // IDLE or NONSEQ ends the burst early.
            state_nxt    = ST_ARB;
            beat_cnt_nxt = 4'd0;
            do_arb       = 1'b1;
          end
        endcase
      end
      default: begin
        state_nxt    = ST_ARB;
        beat_cnt_nxt = 4'd0;
      end
    endcase

    if (do_arb) begin
      grant_idx_nxt = arb_idx;
      rr_ptr_nxt    = arb_ptr;
    end
  end

  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      state     <= ST_ARB;
      beat_cnt  <= 4'd0;
      rr_ptr    <= DEF_IDX;
      HGRANT    <= DEF_GRANT;
      HMASTER   <= 4'(DEFAULT_MASTER);
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
      HGRANT    <= NUM_MASTERS'(1) << grant_idx_nxt;
      HMASTER   <= 4'(grant_idx);
      HMASTLOCK <= HLOCK[grant_idx];
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - self-checking bench for ahb_bus_arbiter

module tb_ahb_bus_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic         clk = 1'b0;
  logic         hrst_n;
  logic [N-1:0] hbusreq;
  logic [N-1:0] hlock;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;
  logic [N-1:0] hgrant;
  logic [3:0]   hmaster;
  logic         hmastlock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_g;
  int m_m;
  bit m_ml;
  int m_ptr;
  bit m_held;
  int m_left;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK      (clk),
    .HRST_N    (hrst_n),
    .HBUSREQ   (hbusreq),
    .HLOCK     (hlock),
    .HTRANS    (htrans),
    .HBURST    (hburst),
    .HREADY    (hready),
    .HGRANT    (hgrant),
    .HMASTER   (hmaster),
    .HMASTLOCK (hmastlock)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hrst_n === 1'b1) begin
      checks++;
      if (!$onehot(hgrant)) begin
        errors++;
        $display("FAIL onehot: HGRANT=%b is not one-hot at %0t", hgrant, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_g = DEF; m_m = DEF; m_ml = 1'b0; m_ptr = DEF; m_held = 1'b0; m_left = 0;
  endtask

  // One HCLK edge of the arbitration rules, applied to the pre-edge inputs.
  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] lck,
                            input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    bit rearb;
    int nm;
    bit nml;
    if (!rdy) return;
    nm    = m_g;
    nml   = lck[m_g];
    rearb = 1'b0;
    if (m_held) begin
      if (tr == 2'b11) begin
        if (m_left == 1) begin
          m_held = 1'b0; m_left = 0; rearb = 1'b1;
        end else begin
          m_left = m_left - 1;
        end
      end else if (tr == 2'b00 || tr == 2'b10) begin
        m_held = 1'b0; m_left = 0; rearb = 1'b1;
      end
    end else if (tr == 2'b10 && bu >= 3'd2) begin
      m_held = 1'b1;
      m_left = (2 << (bu >> 1)) - 1;
    end else begin
      rearb = 1'b1;
    end
    if (rearb && !(lck[m_m] && req[m_m])) begin
      if (req == '0) begin
        m_g = DEF;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (req[c]) begin
            m_g = c; m_ptr = c;
            break;
          end
        end
      end
    end
    m_m  = nm;
    m_ml = nml;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hbusreq = '0; hlock = '0; htrans = 2'b00; hburst = 3'b000; hready = 1'b1;
  endtask

  task automatic do_reset();
    hrst_n = 1'b0;
    set_idle();
    tick();
    hrst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    hrst_n = 1'b0;
    set_idle();
    tick();
    checks++;
    if ({hgrant, hmaster, hmastlock} !== {4'b0001, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: HGRANT=%b HMASTER=%0d HMASTLOCK=%b, want 0001/0/0",
               hgrant, hmaster, hmastlock);
    end
    hrst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({hgrant, hmaster, hmastlock} !== {4'b0001, 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL idle_park[%0d]: HGRANT=%b HMASTER=%0d HMASTLOCK=%b, want 0001/0/0",
                 i, hgrant, hmaster, hmastlock);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [4];
    logic [3:0] exp_m [4];
    exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    exp_m = '{4'd0, 4'd1, 4'd2, 4'd1};
    do_reset();
    hbusreq = 4'b0110; htrans = 2'b10; hburst = 3'b000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (hgrant !== exp_g[i] || hmaster !== exp_m[i]) begin
        errors++;
        $display("FAIL round_robin[%0d]: HGRANT=%b HMASTER=%0d, want %b/%0d",
                 i, hgrant, hmaster, exp_g[i], exp_m[i]);
      end
    end
    set_idle();
  endtask

  // Brings M2 to both HGRANT and HMASTER, then starts INCR4 with M3 waiting.
  task automatic start_m2_incr4(input string tag);
    do_reset();
    hbusreq = 4'b0100;
    tick();
    tick();
    checks++;
    if (hgrant !== 4'b0100 || hmaster !== 4'd2) begin
      errors++;
      $display("FAIL %s_setup: HGRANT=%b HMASTER=%0d, want 0100/2", tag, hgrant, hmaster);
    end
    hbusreq = 4'b1100; htrans = 2'b10; hburst = 3'b011;
    tick();
    checks++;
    if (hgrant !== 4'b0100) begin
      errors++;
      $display("FAIL %s_nonseq: HGRANT=%b, want 0100", tag, hgrant);
    end
    htrans = 2'b11;
  endtask

  task automatic test_burst_handover();
    logic [3:0] want;
    start_m2_incr4("incr4");
    for (int i = 0; i < 3; i++) begin
      tick();
      want = (i < 2) ? 4'b0100 : 4'b1000;
      checks++;
      if (hgrant !== want) begin
        errors++;
        $display("FAIL incr4_seq[%0d]: HGRANT=%b, want %b", i, hgrant, want);
      end
    end
    set_idle();
  endtask

  task automatic test_burst_wait();
    logic [3:0] want;
    start_m2_incr4("wait");
    tick();
    hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (hgrant !== 4'b0100 || hmaster !== 4'd2) begin
        errors++;
        $display("FAIL wait_frozen[%0d]: HGRANT=%b HMASTER=%0d, want 0100/2", i, hgrant, hmaster);
      end
    end
    hready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      want = (i == 0) ? 4'b0100 : 4'b1000;
      checks++;
      if (hgrant !== want) begin
        errors++;
        $display("FAIL wait_resume[%0d]: HGRANT=%b, want %b", i, hgrant, want);
      end
    end
    set_idle();
  endtask

  task automatic test_lock();
    do_reset();
    hbusreq = 4'b0010; hlock = 4'b0010; htrans = 2'b10; hburst = 3'b000;
    tick();
    tick();
    hbusreq = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (hgrant !== 4'b0010 || hmaster !== 4'd1 || hmastlock !== 1'b1) begin
        errors++;
        $display("FAIL lock_hold[%0d]: HGRANT=%b HMASTER=%0d HMASTLOCK=%b, want 0010/1/1",
                 i, hgrant, hmaster, hmastlock);
      end
    end
    hlock = 4'b0000;
    tick();
    checks++;
    if (hgrant !== 4'b1000 || hmastlock !== 1'b0) begin
      errors++;
      $display("FAIL lock_release: HGRANT=%b HMASTLOCK=%b, want 1000/0", hgrant, hmastlock);
    end
    set_idle();
  endtask

  task automatic test_early_term_and_reset();
    do_reset();
    hbusreq = 4'b0010; htrans = 2'b10; hburst = 3'b101;
    tick();
    htrans = 2'b11;
    tick();
    tick();
    checks++;
    if (hgrant !== 4'b0001) begin
      errors++;
      $display("FAIL incr8_held: HGRANT=%b, want 0001", hgrant);
    end
    htrans = 2'b00;
    tick();
    checks++;
    if (hgrant !== 4'b0010 || hmaster !== 4'd0) begin
      errors++;
      $display("FAIL early_term: HGRANT=%b HMASTER=%0d, want 0010/0", hgrant, hmaster);
    end
    tick();
    hbusreq = 4'b0110; htrans = 2'b10; hburst = 3'b101;
    tick();
    htrans = 2'b11;
    tick();
    checks++;
    if (hgrant !== 4'b0010 || hmaster !== 4'd1) begin
      errors++;
      $display("FAIL m1_burst: HGRANT=%b HMASTER=%0d, want 0010/1", hgrant, hmaster);
    end
    #2;
    hrst_n = 1'b0;
    #1;
    checks++;
    if ({hgrant, hmaster, hmastlock} !== {4'b0001, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: HGRANT=%b HMASTER=%0d HMASTLOCK=%b, want 0001/0/0",
               hgrant, hmaster, hmastlock);
    end
    tick();
    hrst_n = 1'b1;
    hbusreq = 4'b0100; htrans = 2'b11;
    tick();
    checks++;
    if (hgrant !== 4'b0100) begin
      errors++;
      $display("FAIL post_reset_arb: HGRANT=%b, want 0100", hgrant);
    end
    set_idle();
  endtask

  task automatic test_random();
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #1;
        hrst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({hgrant, hmaster, hmastlock} !== {4'b0001, 4'd0, 1'b0}) begin
          errors++;
          $display("FAIL rand_reset[%0d]: HGRANT=%b HMASTER=%0d HMASTLOCK=%b, want 0001/0/0",
                   i, hgrant, hmaster, hmastlock);
        end
        tick();
        hrst_n = 1'b1;
      end
      hbusreq = 4'($urandom);
      hlock   = 4'($urandom) & 4'($urandom) & hbusreq;
      hburst  = 3'($urandom);
      if (m_held && $urandom_range(0, 3) != 0) htrans = 2'b11;
      else htrans = 2'($urandom);
      hready = ($urandom_range(0, 3) != 0);
      model_step(hbusreq, hlock, htrans, hburst, hready);
      tick();
      eg = 4'b0001 << m_g;
      checks++;
      if (hgrant !== eg || hmaster !== 4'(m_m) || hmastlock !== m_ml) begin
        errors++;
        $display("FAIL random[%0d]: HGRANT=%b HMASTER=%0d HMASTLOCK=%b, want %b/%0d/%b",
                 i, hgrant, hmaster, hmastlock, eg, m_m, m_ml);
      end
    end
    set_idle();
  endtask

  initial begin
    hrst_n = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_round_robin();
    test_burst_handover();
    test_burst_wait();
    test_lock();
    test_early_term_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin AHB arbiter that shares the AHB address/data bus, and the ahb2apb bridge slave behind it, among up to NUM_MASTERS masters.
- Generates HGRANT, HMASTER and HMASTLOCK for the master-side muxes and the bridge.
- Holds ownership for the full length of fixed-length bursts and for locked sequences.
- Parks the bus on a default master when nobody requests.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, index granted when there are no requests; also the reset owner

Ports:
HCLK  input  1  AHB clock
HRST_N  input  1  asynchronous, active-low reset
HBUSREQ  input  NUM_MASTERS  per-master bus request
HLOCK  input  NUM_MASTERS  per-master locked-transfer request
HTRANS  input  2  address-phase transfer type of current owner (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
HBURST  input  3  address-phase burst type of current owner
HREADY  input  1  bus-wide ready (bridge HREADY_o muxed with other slaves)
HGRANT  output  NUM_MASTERS  one-hot grant, registered
HMASTER  output  4  index of master owning the address phase, registered
HMASTLOCK  output  1  current address phase is part of a locked sequence, registered

Behaviour:
- Reset: HGRANT one-hot at DEFAULT_MASTER; HMASTER=DEFAULT_MASTER; HMASTLOCK=0; state ARB; beat counter=0; rr pointer=DEFAULT_MASTER.
- All state updates happen only on HCLK edges where HREADY=1. When HREADY=0, every register holds its value (wait states freeze arbitration).
- State ARB (free):
  - On an HREADY edge, if the owner (HMASTER) has HLOCK=1 and HBUSREQ=1, HGRANT is unchanged.
  - Otherwise new grant = first requesting master searching upward from pointer+1, wrapping modulo NUM_MASTERS; pointer <= new grant index.
  - No requests -> grant DEFAULT_MASTER; pointer unchanged.
  - A fixed burst starts when the owner presents NONSEQ with HBURST in {WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111}. Then load counter = beats-1 (3/7/15), go to BURST, and keep HGRANT unchanged.
  - SINGLE (000) and INCR (001) do not enter BURST; re-arbitration is allowed every beat.
- State BURST (held):
  - HGRANT is frozen.
  - SEQ accepted with HREADY=1 -> counter-1.
  - BUSY -> no change.
  - When SEQ is accepted with counter==1 (last address beat), go to ARB and perform the ARB grant selection on the same edge, so the new owner gets HGRANT during the last data phase.
  - Early termination: IDLE or NONSEQ seen with HREADY=1 -> clear counter, go to ARB, arbitrate on the same edge.
- HMASTER <= index of the current HGRANT on each HREADY edge. It lags HGRANT by one accepted cycle, as AHB address-phase ownership does.
- HMASTLOCK <= HLOCK[index of current HGRANT] on each HREADY edge.
- Simultaneous requests: only round-robin order applies; no fixed priority except DEFAULT_MASTER parking.
- A requester that drops HBUSREQ while granted keeps the grant until the next ARB edge.
- Mid-operation reset returns immediately (asynchronously) to the reset values; any burst in progress is abandoned.
- HMASTER bits above $clog2(NUM_MASTERS) are 0.
- HGRANT is always exactly one-hot. The bench asserts this on every cycle out of reset.

Test Plan:
- Reset then idle, no HBUSREQ, 10 cycles -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 throughout.
- HBUSREQ=0110 held, SINGLE NONSEQ every cycle, HREADY=1 -> grant sequence M1,M2,M1,M2 on consecutive edges; HMASTER follows one cycle later.
- M2 issues INCR4 (NONSEQ + 3 SEQ) while M3 requests -> HGRANT stays 0100 for the 4 address beats and switches to 1000 on the edge accepting the 3rd SEQ.
- Same INCR4 with HREADY=0 inserted for 2 cycles after beat 2 -> counter and grant frozen during the wait; handover is delayed exactly 2 cycles.
- M1 HLOCK=1 and HBUSREQ=1 for 5 transfers while M0 and M3 request -> HGRANT=0010 and HMASTLOCK=1 for all 5; after HLOCK drops, the grant goes to M3.
- INCR8 from M0 terminated by IDLE after 3 beats while M1 requests -> state returns to ARB and HGRANT=0010 on that edge; HRST_N pulsed mid-burst -> HGRANT=0001, HMASTER=0 immediately.
